// File: rtl/breakout_vid_pkg.sv
// breakout_vid_pkg: shared timing defaults, sync polarity constants and move-window state encoding
package breakout_vid_pkg;

  // 640x480@60 timing, 25.175 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_TOTAL  = 525;

  localparam bit ACTIVE_HIGH = 1'b1;
  localparam bit ACTIVE_LOW  = 1'b0;

  // Ball-move window: IDLE during the frame, MOVE for 2^MOVE_LOG2 cycles after frame_tick
  typedef enum logic {
    MV_IDLE = 1'b0,
    MV_MOVE = 1'b1
  } move_state_e;

endpackage

// File: rtl/breakout_delay_line.sv
// breakout_delay_line: WIDTH x DEPTH shift register with asynchronous active-low clear
//   clk    pixel clock
//   rst_n  asynchronous active-low clear, all stages to 0
//   d_i    input word
//   q_o    d_i delayed by DEPTH cycles (DEPTH = 0 is a plain wire)
module breakout_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/breakout_vga_timing.sv
// breakout_vga_timing: parametrised VGA timing, RGB masking and per-frame ball-move window
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low forces counters to 0 and aborts the move window
//   rgb_in       renderer pixel for the counter position PIPE-1 cycles earlier
//   counter_x/y  registered pixel column / line
//   draw_area    visible region, PIPE cycles after the counters
//   h_sync/v_sync sync pulses with HS_POL/VS_POL polarity, PIPE cycles after the counters
//   rgb_out      rgb_in masked to the visible region, aligned with draw_area
//   line_tick    last clock of every line (combinational)
//   frame_tick   last clock of the last visible line (combinational)
//   move_window  high for 2^MOVE_LOG2 cycles starting the cycle after frame_tick
//   move_phase   cycle index inside the move window, 0 when idle
//   frame_count  completed frames, modulo 2^FRAME_W
module breakout_vga_timing
  import breakout_vid_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter bit HS_POL    = ACTIVE_HIGH,
  parameter bit VS_POL    = ACTIVE_HIGH,
  parameter int PIPE      = 1,
  parameter int MOVE_LOG2 = 6,
  parameter int CW        = 10,
  parameter int RW        = 10,
  parameter int FRAME_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2:0]           rgb_in,
  output logic [CW-1:0]        counter_x,
  output logic [RW-1:0]        counter_y,
  output logic                 draw_area,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [2:0]           rgb_out,
  output logic                 line_tick,
  output logic                 frame_tick,
  output logic                 move_window,
  output logic [MOVE_LOG2-1:0] move_phase,
  output logic [FRAME_W-1:0]   frame_count
);

  if (PIPE < 1) begin : g_chk_pipe
    $error("breakout_vga_timing: PIPE must be >= 1");
  end
  if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_chk_h
    $error("breakout_vga_timing: horizontal timing exceeds H_TOTAL");
  end
  if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_chk_v
    $error("breakout_vga_timing: vertical timing exceeds V_TOTAL");
  end
  if ((1 << MOVE_LOG2) >= (V_TOTAL - V_ACTIVE) * H_TOTAL) begin : g_chk_move
    $error("breakout_vga_timing: move window does not fit in vertical blanking");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << RW)) begin : g_chk_cw
    $error("breakout_vga_timing: counter widths too small");
  end

  // Boundaries held one bit wider than the counters: a sync pulse may end exactly at 2^CW
  localparam logic [CW:0] X_LAST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] X_VIS  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] X_HS0  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] X_HS1  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [RW:0] Y_LAST = (RW+1)'(V_TOTAL - 1);
  localparam logic [RW:0] Y_VLST = (RW+1)'(V_ACTIVE - 1);
  localparam logic [RW:0] Y_VIS  = (RW+1)'(V_ACTIVE);
  localparam logic [RW:0] Y_VS0  = (RW+1)'(V_ACTIVE + V_FP);
  localparam logic [RW:0] Y_VS1  = (RW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]        x_q, x_d;
  logic [RW-1:0]        y_q, y_d;
  logic [CW:0]          x_w;
  logic [RW:0]          y_w;
  logic                 x_end, y_end;
  logic [2:0]           dec0, dec_pre;
  logic                 da_q, hs_q, vs_q;
  logic [2:0]           rgb_q;
  logic [FRAME_W-1:0]   frame_q;
  move_state_e          state_q;
  logic [MOVE_LOG2-1:0] phase_q;
  logic                 win_q;

  assign x_w   = {1'b0, x_q};
  assign y_w   = {1'b0, y_q};
  assign x_end = x_w == X_LAST;
  assign y_end = y_w == Y_LAST;

  always_comb begin
    x_d = (!en || x_end) ? '0 : x_q + CW'(1);
    y_d = !en ? '0 : !x_end ? y_q : y_end ? '0 : y_q + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Stage-0 decode {da, hs, vs}, active-high internally; polarity is applied at the pins
  assign dec0 = en ? {x_w < X_VIS && y_w < Y_VIS,
                      x_w >= X_HS0 && x_w < X_HS1,
                      y_w >= Y_VS0 && y_w < Y_VS1} : 3'b000;

  // First PIPE-1 stages; the last stage is below so rgb can be gated by the stage PIPE-1 da
  breakout_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE - 1)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (dec0),
    .q_o  (dec_pre)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {da_q, hs_q, vs_q} <= 3'b000;
      rgb_q              <= '0;
    end else begin
      {da_q, hs_q, vs_q} <= dec_pre;
      rgb_q              <= dec_pre[2] ? rgb_in : 3'b000;
    end
  end

  assign counter_x = x_q;
  assign counter_y = y_q;
  assign draw_area = da_q;
  assign h_sync    = ~(hs_q ^ HS_POL);
  assign v_sync    = ~(vs_q ^ VS_POL);
  assign rgb_out   = rgb_q;

  assign line_tick  = en & x_end;
  assign frame_tick = line_tick & (y_w == Y_VLST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else if (frame_tick) frame_q <= frame_q + FRAME_W'(1);
  end

  assign frame_count = frame_q;

  // A frame_tick can only arrive in IDLE: the window is shorter than vertical blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MV_IDLE;
      phase_q <= '0;
      win_q   <= 1'b0;
    end else if (!en) begin
      state_q <= MV_IDLE;
      phase_q <= '0;
      win_q   <= 1'b0;
    end else begin
      case (state_q)
        MV_IDLE: begin
          if (frame_tick) begin
            state_q <= MV_MOVE;
            win_q   <= 1'b1;
          end
          phase_q <= '0;
        end
        MV_MOVE: begin
          if (&phase_q) begin
            state_q <= MV_IDLE;
            win_q   <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + MOVE_LOG2'(1);
          end
        end
        default: begin
          state_q <= MV_IDLE;
          win_q   <= 1'b0;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign move_window = win_q;
  assign move_phase  = phase_q;

endmodule

// File: tb/tb_breakout_vga_timing.sv
// tb_breakout_vga_timing: three timing configurations checked cycle by cycle against an arithmetic frame model
module tb_breakout_vga_timing;

  localparam int N = 3;
  localparam int HA[N] = '{16, 16, 640};
  localparam int HF[N] = '{4, 4, 16};
  localparam int HS[N] = '{6, 12, 96};
  localparam int HT[N] = '{32, 32, 800};
  localparam int VA[N] = '{12, 12, 480};
  localparam int VF[N] = '{2, 2, 10};
  localparam int VS[N] = '{2, 6, 2};
  localparam int VT[N] = '{20, 20, 525};
  localparam int HP[N] = '{1, 0, 1};
  localparam int VP[N] = '{1, 0, 1};
  localparam int PP[N] = '{1, 3, 1};
  localparam int ML[N] = '{4, 3, 6};
  localparam int FW[N] = '{2, 4, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [2:0] rgb_in = 3'b000;

  always #5 clk = ~clk;

  logic [4:0] x0, y0; logic [5:0] x1; logic [4:0] y1; logic [9:0] x2, y2;
  logic d0, h0, v0, lt0, ft0, mw0, d1, h1, v1, lt1, ft1, mw1, d2, h2, v2, lt2, ft2, mw2;
  logic [2:0] c0, c1, c2;
  logic [3:0] mp0; logic [2:0] mp1; logic [5:0] mp2;
  logic [1:0] fc0; logic [3:0] fc1; logic [15:0] fc2;

  breakout_vga_timing #(.H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_TOTAL(HT[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_TOTAL(VT[0]), .HS_POL(1'b1), .VS_POL(1'b1),
    .PIPE(1), .MOVE_LOG2(4), .CW(5), .RW(5), .FRAME_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .rgb_in(rgb_in), .counter_x(x0), .counter_y(y0),
    .draw_area(d0), .h_sync(h0), .v_sync(v0), .rgb_out(c0), .line_tick(lt0), .frame_tick(ft0),
    .move_window(mw0), .move_phase(mp0), .frame_count(fc0));

  breakout_vga_timing #(.H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_TOTAL(HT[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_TOTAL(VT[1]), .HS_POL(1'b0), .VS_POL(1'b0),
    .PIPE(3), .MOVE_LOG2(3), .CW(6), .RW(5), .FRAME_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .rgb_in(rgb_in), .counter_x(x1), .counter_y(y1),
    .draw_area(d1), .h_sync(h1), .v_sync(v1), .rgb_out(c1), .line_tick(lt1), .frame_tick(ft1),
    .move_window(mw1), .move_phase(mp1), .frame_count(fc1));

  breakout_vga_timing dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .rgb_in(rgb_in), .counter_x(x2), .counter_y(y2),
    .draw_area(d2), .h_sync(h2), .v_sync(v2), .rgb_out(c2), .line_tick(lt2), .frame_tick(ft2),
    .move_window(mw2), .move_phase(mp2), .frame_count(fc2));

  logic [15:0] o_x[N], o_y[N], o_mp[N], o_fc[N];
  logic        o_da[N], o_hs[N], o_vs[N], o_lt[N], o_ft[N], o_mw[N];
  logic [2:0]  o_rgb[N];

  assign o_x[0] = 16'(x0);  assign o_x[1] = 16'(x1);  assign o_x[2] = 16'(x2);
  assign o_y[0] = 16'(y0);  assign o_y[1] = 16'(y1);  assign o_y[2] = 16'(y2);
  assign o_mp[0] = 16'(mp0); assign o_mp[1] = 16'(mp1); assign o_mp[2] = 16'(mp2);
  assign o_fc[0] = 16'(fc0); assign o_fc[1] = 16'(fc1); assign o_fc[2] = fc2;
  assign o_da[0] = d0;  assign o_da[1] = d1;  assign o_da[2] = d2;
  assign o_hs[0] = h0;  assign o_hs[1] = h1;  assign o_hs[2] = h2;
  assign o_vs[0] = v0;  assign o_vs[1] = v1;  assign o_vs[2] = v2;
  assign o_lt[0] = lt0; assign o_lt[1] = lt1; assign o_lt[2] = lt2;
  assign o_ft[0] = ft0; assign o_ft[1] = ft1; assign o_ft[2] = ft2;
  assign o_mw[0] = mw0; assign o_mw[1] = mw1; assign o_mw[2] = mw2;
  assign o_rgb[0] = c0; assign o_rgb[1] = c1; assign o_rgb[2] = c2;

  // Model: r = linear pixel index inside the frame; history of visible/sync flags per clock
  int total = 0;
  int bad = 0;
  int r[N], win[N], fc[N];
  bit hda[N][8], hhs[N][8], hvs[N][8];
  logic [2:0] e_rgb;
  int cnt_lt, cnt_ft, cnt_hs2, cnt_rgb0, cnt_rgb1;
  int off;
  bit n_en;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0d want=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_rgb = 3'b000;
    for (int i = 0; i < N; i++) begin
      r[i] = 0; win[i] = -1; fc[i] = 0;
      for (int s = 0; s < 8; s++) begin hda[i][s] = 0; hhs[i][s] = 0; hvs[i][s] = 0; end
    end
  endtask

  task automatic model_edge();
    e_rgb = rgb_in;
    for (int i = 0; i < N; i++) begin
      int x, y;
      bit ft;
      x = r[i] % HT[i];
      y = r[i] / HT[i];
      for (int s = 7; s > 0; s--) begin
        hda[i][s] = hda[i][s-1]; hhs[i][s] = hhs[i][s-1]; hvs[i][s] = hvs[i][s-1];
      end
      hda[i][0] = en && x < HA[i] && y < VA[i];
      hhs[i][0] = en && x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HS[i];
      hvs[i][0] = en && y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VS[i];
      ft = en && r[i] == VA[i] * HT[i] - 1;
      if (!en) win[i] = -1;
      else if (ft) win[i] = 0;
      else if (win[i] >= 0) win[i] = (win[i] + 1 == (1 << ML[i])) ? -1 : win[i] + 1;
      if (ft) fc[i] = (fc[i] + 1) % (1 << FW[i]);
      r[i] = en ? (r[i] + 1) % (HT[i] * VT[i]) : 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int x, y, p;
      bit da, lt;
      x = r[i] % HT[i];
      y = r[i] / HT[i];
      p = PP[i];
      da = hda[i][p-1];
      lt = en && x == HT[i] - 1;
      chk("counter_x", i, o_x[i], x);
      chk("counter_y", i, o_y[i], y);
      chk("draw_area", i, o_da[i], da);
      chk("h_sync", i, o_hs[i], hhs[i][p-1] == HP[i][0]);
      chk("v_sync", i, o_vs[i], hvs[i][p-1] == VP[i][0]);
      chk("rgb_out", i, o_rgb[i], da ? e_rgb : 3'b000);
      chk("line_tick", i, o_lt[i], lt);
      chk("frame_tick", i, o_ft[i], lt && y == VA[i] - 1);
      chk("move_window", i, o_mw[i], win[i] >= 0);
      chk("move_phase", i, o_mp[i], win[i] < 0 ? 0 : win[i]);
      chk("frame_count", i, o_fc[i], fc[i]);
    end
  endtask

  task automatic step(input bit ne, input logic [2:0] nrgb);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    en = ne;
    rgb_in = nrgb;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);

    // Five clean frames of the small configs with a white renderer
    cnt_lt = 0; cnt_ft = 0; cnt_hs2 = 0; cnt_rgb0 = 0; cnt_rgb1 = 0;
    for (int k = 0; k < 3200; k++) begin
      step(1'b1, 3'b111);
      cnt_lt += int'(o_lt[0]);
      cnt_ft += int'(o_ft[0]);
      cnt_hs2 += int'(o_hs[2]);
      cnt_rgb0 += int'(o_rgb[0] == 3'b111);
      cnt_rgb1 += int'(o_rgb[1] == 3'b111);
    end
    chk("line_ticks_5_frames", 0, cnt_lt, 100);
    chk("frame_ticks_5_frames", 0, cnt_ft, 5);
    chk("hsync_high_4_lines", 2, cnt_hs2, 384);
    chk("white_pixels_5_frames", 0, cnt_rgb0, 960);
    chk("white_pixels_5_frames", 1, cnt_rgb1, 960);

    // Drop en while config 1 is inside its (active-low) h_sync pulse
    for (int k = 0; k < 700 && r[0] != 5 * 32 + 22; k++) step(1'b1, 3'($urandom));
    chk("reach_drop_point", 1, o_x[1], 22);
    for (int k = 0; k < 4; k++) step(1'b0, 3'($urandom));
    chk("stopped_x", 1, o_x[1], 0);
    chk("stopped_h_sync_idle", 1, o_hs[1], 1);
    chk("stopped_v_sync_idle", 1, o_vs[1], 1);
    chk("stopped_draw_area", 1, o_da[1], 0);

    // Random renderer data with occasional en dropouts of random length
    off = 0;
    for (int k = 0; k < 1500; k++) begin
      if (off > 0) begin off--; n_en = 1'b0; end
      else if ($urandom_range(0, 499) == 0) begin off = $urandom_range(0, 7); n_en = 1'b0; end
      else n_en = 1'b1;
      step(n_en, 3'($urandom));
    end

    // Asynchronous reset in the middle of a move window
    for (int k = 0; k < 1500 && win[0] != 10; k++) step(1'b1, 3'($urandom));
    chk("reach_move_phase_10", 0, o_mp[0], 10);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) step(1'b1, 3'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
